fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction buffer between the fetch stage and the decoder.
- Accepts fetched instruction words with their PC and the fetch-stage branch prediction bit. Presents them in order to the decode stage through a valid/ready handshake.
- Decouples fetch from decode stalls.
- Discards all buffered instructions on a pipeline flush (branch mispredict, exception redirect).

Parameters:
- INST, 32, instruction word width.
- ADDR, 32, PC width.
- DEPTH, 4, number of entries. Must be a power of two, at least 2.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  discard all entries; takes effect at this clock edge.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  queue can accept an entry this cycle.
- in_inst  input  INST  fetched instruction word.
- in_pc  input  ADDR  PC of in_inst.
- in_pred  input  1  fetch predicted this instruction taken.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  decode stage consumes the head this cycle.
- out_inst  output  INST  head instruction; drives the decoder inst input.
- out_pc  output  ADDR  head PC.
- out_pred  output  1  head prediction bit.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: DEPTH-entry circular buffer holding {inst, pc, pred}.
- Pointers: head (rd_ptr) and tail (wr_ptr), each $clog2(DEPTH)+1 bits with a wrap bit.
  - empty = pointers equal.
  - full = index bits equal and wrap bits differ.
- Handshake:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - in_ready = !full & !flush, combinational from registered state and flush.
  - out_valid = !empty.
  - out_inst, out_pc and out_pred read the head entry combinationally.
  - When empty, out_inst/out_pc/out_pred are 0, so the decoder sees an all-zero word. The consumer must qualify with out_valid.
- Latency:
  - An entry pushed at edge N is visible on out_* after edge N. Minimum push-to-pop latency is 1 cycle.
  - There is no same-cycle bypass from in_* to out_*.
- Simultaneous push and pop:
  - When not empty and not full, both proceed and count is unchanged.
  - When full, in_ready = 0, so no push occurs even if a pop happens. The slot frees at the next edge.
  - When empty, only the push occurs. The pop is impossible because out_valid = 0.
- Pointer wrap: both pointers increment modulo 2*DEPTH. The index is ptr[$clog2(DEPTH)-1:0].
- count = wr_ptr - rd_ptr, computed modulo 2*DEPTH, range 0..DEPTH.
- Flush:
  - At the edge where flush = 1, rd_ptr and wr_ptr are both set to 0 and count becomes 0.
  - Any push or pop in that cycle is discarded. in_ready is forced to 0.
  - out_valid may still be 1 combinationally in the flush cycle. Decode must ignore it under flush.
- Reset:
  - On reset = 1 at a clock edge: pointers = 0, all entry storage = 0.
  - After reset: out_valid = 0, out_inst = 0, out_pc = 0, out_pred = 0, count = 0, in_ready = 1.
  - reset overrides flush and any handshake in the same cycle.
  - Reset applied mid-operation drops all entries identically to a flush.
- Entry payload is not cleared on pop or flush; only the pointers move.
- The queue has no state machine beyond pointer/occupancy tracking. Its occupancy states are EMPTY (count = 0), PARTIAL (1..DEPTH-1) and FULL (count = DEPTH).
  - EMPTY -> PARTIAL on push.
  - PARTIAL -> FULL on push without pop at count = DEPTH-1.
  - FULL -> PARTIAL on pop.
  - PARTIAL -> EMPTY on pop without push at count = 1.
  - Any state -> EMPTY on flush or reset.
- Assertions in simulation only:
  - No push when full.
  - No pop when empty.
  - count never exceeds DEPTH.

Test Plan:
1. Reset, then push inst 0x00000013 with pc 0x1000 and pred = 0, out_ready = 0. Next cycle: out_valid = 1, out_inst = 0x00000013, out_pc = 0x1000, count = 1.
2. With DEPTH = 4 and out_ready = 0, push 5 consecutive instructions (pc 0x1000..0x1010). The first 4 are accepted; in_ready = 0 after the 4th; count = 4; the 5th is held by fetch. Then pop 4 times with out_ready = 1: out_pc reads 0x1000, 0x1004, 0x1008, 0x100C in order.
3. Hold in_valid = 1 and out_ready = 1 for 12 cycles with incrementing pc. count stays at 1 after the first cycle, pointers wrap past 2*DEPTH, and the output sequence is in order with no loss or duplication.
4. Fill 3 entries, then assert flush together with in_valid = 1 and out_ready = 1. Next cycle: count = 0, out_valid = 0, in_ready = 1, and the flush-cycle push is not present.
5. Fill to FULL, assert reset = 1 for one cycle with in_valid = 1. After it: count = 0, out_valid = 0, out_inst = 0, out_pc = 0, out_pred = 0, in_ready = 1. A push of pc 0x2000 then appears as the head.
6. Push a branch with pred = 1 and pc 0x3000 behind an entry with pred = 0. out_pred is 0 for the first pop and 1 for the second, each aligned with its own pc.

Source files
------------

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Instruction buffer between the fetch stage and the decoder. It holds up to
//   DEPTH {inst, pc, pred} entries in a circular buffer and presents them in
//   order to decode. This lets fetch keep running while decode is stalled.
//   A flush discards every buffered entry.
//
// Handshake:
//   A transfer happens on a rising clk edge where valid & ready are both 1.
//   The producer holds its payload stable while valid=1 and ready=0. Ready
//   never depends on the same-side valid.
//     push = in_valid  & in_ready   (in_ready  = !full & !flush)
//     pop  = out_valid & out_ready  (out_valid = !empty)
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   flush                      drop all entries at this edge
//   in_valid/in_ready          fetch-side handshake
//   in_inst/in_pc/in_pred      fetched word, its PC, predicted-taken bit
//   out_valid/out_ready        decode-side handshake
//   out_inst/out_pc/out_pred   head entry; all zero while empty
//   count                      occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int INST  = 32,
  parameter int ADDR  = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INST-1:0]            in_inst,
  input  logic [ADDR-1:0]            in_pc,
  input  logic                       in_pred,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INST-1:0]            out_inst,
  output logic [ADDR-1:0]            out_pc,
  output logic                       out_pred,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Storage
  logic [INST-1:0] inst_q [DEPTH];
  logic [ADDR-1:0] pc_q   [DEPTH];
  logic            pred_q [DEPTH];

  // Pointers carry one extra wrap bit above the index.
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;

  logic [AW-1:0] rd_idx, wr_idx;
  logic          empty, full;
  logic          push, pop;

  assign rd_idx = rd_ptr_q[AW-1:0];
  assign wr_idx = wr_ptr_q[AW-1:0];

  assign empty = (rd_ptr_q == wr_ptr_q);
  // Same slot index but a different lap: the writer is a full lap ahead.
  assign full  = (rd_idx == wr_idx) && (rd_ptr_q[AW] != wr_ptr_q[AW]);

  assign in_ready  = !full && !flush;
  assign out_valid = !empty;

  assign push = in_valid  && in_ready;
  assign pop  = out_valid && out_ready;

  // Modulo-2*DEPTH difference falls naturally out of the PW-bit subtraction.
  assign count = wr_ptr_q - rd_ptr_q;

  // Head read. Zeroed while empty so the decoder sees a quiet all-zero word.
  assign out_inst = empty ? '0   : inst_q[rd_idx];
  assign out_pc   = empty ? '0   : pc_q[rd_idx];
  assign out_pred = empty ? 1'b0 : pred_q[rd_idx];

  // Pointer next-state. Flush wins over any same-cycle push or pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
        pred_q[i] <= 1'b0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      // Payload is only ever overwritten by a push. Pop and flush move
      // pointers only.
      if (push) begin
        inst_q[wr_idx] <= in_inst;
        pc_q[wr_idx]   <= in_pc;
        pred_q[wr_idx] <= in_pred;
      end
    end
  end

`ifndef SYNTHESIS
  a_no_push_full: assert property (@(posedge clk) disable iff (reset)
    !(push && full));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset)
    !(pop && empty));
  a_count_range:  assert property (@(posedge clk) disable iff (reset)
    count <= PW'(DEPTH));
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//   Bench for fetch_queue (DEPTH=4). A queue of {pred, pc, inst} entries is the
//   reference: it accepts a push while it holds fewer than DEPTH entries and
//   no flush is present. It returns its front on a pop, and empties on a
//   flush or reset. Inputs change on the falling edge. Outputs are sampled
//   1 ns later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

  localparam int INST  = 32;
  localparam int ADDR  = 32;
  localparam int DEPTH = 4;
  localparam int W     = 1 + ADDR + INST;

  logic            clk;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [INST-1:0] in_inst;
  logic [ADDR-1:0] in_pc;
  logic            in_pred;
  logic            out_valid;
  logic            out_ready;
  logic [INST-1:0] out_inst;
  logic [ADDR-1:0] out_pc;
  logic            out_pred;
  logic [2:0]      count;

  logic [W-1:0] exp_q[$];

  int n_cmp;
  int n_err;

  fetch_queue #(.INST(INST), .ADDR(ADDR), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .in_pred   (in_pred),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_pc    (out_pc),
    .out_pred  (out_pred),
    .count     (count)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- drivers
  task automatic drive(input logic v, input logic [INST-1:0] inst,
                       input logic [ADDR-1:0] pc, input logic pred,
                       input logic rdy, input logic fl, input logic rst);
    in_valid  = v;
    in_inst   = inst;
    in_pc     = pc;
    in_pred   = pred;
    out_ready = rdy;
    flush     = fl;
    reset     = rst;
    #1;
  endtask

  // Advance one clock, updating the reference from the inputs held across
  // the rising edge. Returns at the next falling edge.
  task automatic tick();
    logic do_push, do_pop;
    do_push = in_valid && (exp_q.size() < DEPTH) && !flush;
    do_pop  = out_ready && (exp_q.size() > 0);
    @(posedge clk);
    if (reset || flush) begin
      exp_q.delete();
    end else begin
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({in_pred, in_pc, in_inst});
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    drive(1'b1, 32'hdead_beef, 32'h1234, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ctrl: out_valid=%b count=%0d in_ready=%b, want 0/0/1",
               out_valid, count, in_ready);
    end
    n_cmp++;
    if (out_inst !== 32'd0 || out_pc !== 32'd0 || out_pred !== 1'b0) begin
      n_err++;
      $display("FAIL reset_data: inst=%h pc=%h pred=%b, want all zero",
               out_inst, out_pc, out_pred);
    end
  endtask

  task automatic test_single_push();
    do_reset();
    drive(1'b1, 32'h0000_0013, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL single_pre: in_ready=%b out_valid=%b, want 1/0 (no bypass)",
               in_ready, out_valid);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_inst !== 32'h13 || out_pc !== 32'h1000 ||
        out_pred !== 1'b0 || count !== 3'd1) begin
      n_err++;
      $display("FAIL single_head: v=%b inst=%h pc=%h pred=%b count=%0d, want 1/13/1000/0/1",
               out_valid, out_inst, out_pc, out_pred, count);
    end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h100 + i, 32'h1000 + 4 * i, 1'b0, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (in_ready !== (i < DEPTH)) begin
        n_err++;
        $display("FAIL fill_ready[%0d]: in_ready=%b want %b", i, in_ready, (i < DEPTH));
      end
      tick();
    end
    drive(1'b1, 32'h104, 32'h1010, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL fill_full: count=%0d in_ready=%b want 4/0", count, in_ready);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b1 || out_pc !== 32'h1000 + 4 * i) begin
        n_err++;
        $display("FAIL drain_pc[%0d]: v=%b pc=%h want 1/%h", i, out_valid, out_pc,
                 32'h1000 + 4 * i);
      end
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      n_err++;
      $display("FAIL drain_empty: v=%b count=%0d want 0/0", out_valid, count);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 32'h500 + k, 32'h4000 + 4 * k, k[0], 1'b1, 1'b0, 1'b0);
      if (k > 0) begin
        n_cmp++;
        if (count !== 3'd1 || out_valid !== 1'b1 || out_pc !== 32'h4000 + 4 * (k - 1) ||
            out_inst !== 32'h500 + (k - 1)) begin
          n_err++;
          $display("FAIL b2b[%0d]: count=%0d v=%b pc=%h inst=%h want 1/1/%h/%h", k,
                   count, out_valid, out_pc, out_inst, 32'h4000 + 4 * (k - 1),
                   32'h500 + (k - 1));
        end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h700 + i, 32'h5000 + 4 * i, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h7ff, 32'h5ffc, 1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (in_ready !== 1'b0 || count !== 3'd3) begin
      n_err++;
      $display("FAIL flush_cycle: in_ready=%b count=%0d want 0/3", in_ready, count);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
        out_pc !== 32'd0) begin
      n_err++;
      $display("FAIL flush_after: count=%0d v=%b in_ready=%b pc=%h want 0/0/1/0",
               count, out_valid, in_ready, out_pc);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h900 + i, 32'h6000 + 4 * i, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h9ff, 32'h6ffc, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1 ||
        out_inst !== 32'd0 || out_pc !== 32'd0 || out_pred !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: count=%0d v=%b rdy=%b inst=%h pc=%h pred=%b want 0/0/1/0/0/0",
               count, out_valid, in_ready, out_inst, out_pc, out_pred);
    end
    drive(1'b1, 32'h0000_0067, 32'h2000, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_pc !== 32'h2000 || out_inst !== 32'h67 ||
        count !== 3'd1) begin
      n_err++;
      $display("FAIL reset_mid_push: v=%b pc=%h inst=%h count=%0d want 1/2000/67/1",
               out_valid, out_pc, out_inst, count);
    end
  endtask

  task automatic test_pred();
    do_reset();
    drive(1'b1, 32'h0000_0013, 32'h2ffc, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h0000_0063, 32'h3000, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (out_pred !== 1'b0 || out_pc !== 32'h2ffc) begin
      n_err++;
      $display("FAIL pred_first: pred=%b pc=%h want 0/2ffc", out_pred, out_pc);
    end
    tick();
    n_cmp++;
    if (out_pred !== 1'b1 || out_pc !== 32'h3000 || out_inst !== 32'h63) begin
      n_err++;
      $display("FAIL pred_second: pred=%b pc=%h inst=%h want 1/3000/63",
               out_pred, out_pc, out_inst);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] head;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 3) != 0), $urandom(), $urandom(),
            1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 24) == 0), ($urandom_range(0, 99) == 0));
      head = (exp_q.size() > 0) ? exp_q[0] : '0;
      n_cmp++;
      if (out_valid !== (exp_q.size() > 0) || count !== 3'(exp_q.size()) ||
          in_ready !== ((exp_q.size() < DEPTH) && !flush) ||
          {out_pred, out_pc, out_inst} !== head) begin
        n_err++;
        $display("FAIL random[%0d]: v=%b cnt=%0d rdy=%b head=%h want v=%b cnt=%0d rdy=%b head=%h",
                 k, out_valid, count, in_ready, {out_pred, out_pc, out_inst},
                 (exp_q.size() > 0), exp_q.size(),
                 ((exp_q.size() < DEPTH) && !flush), head);
      end
      tick();
    end
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    n_cmp     = 0;
    n_err     = 0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_pc     = '0;
    in_pred   = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_push();
    test_fill_drain();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_pred();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
